// File: rtl/con_ff_unit.sv
// -----------------------------------------------------------------------------
// con_ff_unit
// Condition-code flip-flop for the datapath branch logic. On each rising edge
// of con_in the bus value is tested against cond_code and the result is
// latched into con_out. Provides an illegal-code flag, a valid/clear handshake
// and, when the CON_STATS_EN macro is defined, saturating branch statistics.
//
// Parameters
//   DATA_W  width of bus_in (two's complement)
//   CODE_W  width of cond_code (minimum 4)
//   CNT_W   width of the statistics counters (CON_STATS_EN only)
//
// Ports
//   clock      in   system clock, all state on rising edge
//   clear      in   asynchronous active-low reset
//   bus_in     in   value under test
//   cond_code  in   condition select
//   con_in     in   evaluate request, acted on at its 0->1 transition
//   con_clr    in   drop the current result (con_out, con_valid -> 0)
//   con_out    out  latched condition result
//   con_valid  out  con_out holds a live evaluation
//   cond_ill   out  last evaluation used an undefined code
//   eval_cnt   out  evaluations performed          (CON_STATS_EN only)
//   taken_cnt  out  evaluations that returned 1    (CON_STATS_EN only)
//
// Optional feature macro: CON_STATS_EN
// -----------------------------------------------------------------------------
module con_ff_unit #(
    parameter int DATA_W = 32,
    parameter int CODE_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [CODE_W-1:0] cond_code,
    input  logic              con_in,
    input  logic              con_clr,
    output logic              con_out,
    output logic              con_valid,
    output logic              cond_ill
`ifdef CON_STATS_EN
    ,
    output logic [CNT_W-1:0]  eval_cnt,
    output logic [CNT_W-1:0]  taken_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_e;

    // Parameter sanity: codes 0..7 need at least four bits so that codes
    // above 7 remain expressible and flagged as illegal.
    if (CODE_W < 4 || CNT_W < 1) begin : g_bad_param
        $error("con_ff_unit: CODE_W must be >= 4 and CNT_W >= 1");
    end

    // Returns {illegal, result} for a bus value and condition code.
    function automatic logic [1:0] cond_eval(input logic [DATA_W-1:0] bus,
                                             input logic [CODE_W-1:0] code);
        logic z;
        logic n;
        logic d;
        logic ill;
        z   = ~|bus;
        n   = bus[DATA_W-1];
        d   = 1'b0;
        ill = 1'b0;
        if (|code[CODE_W-1:3]) begin
            ill = 1'b1;
            d   = 1'b0;
        end else begin
            case (code[2:0])
                3'd0:    d = z;
                3'd1:    d = ~z;
                3'd2:    d = ~n;
                3'd3:    d = n;
                3'd4:    d = ~n & ~z;
                3'd5:    d = n | z;
                3'd6:    d = 1'b1;
                3'd7:    d = 1'b0;
                default: d = 1'b0;
            endcase
        end
        return {ill, d};
    endfunction

    state_e     state_q, state_d;
    logic       con_in_q;
    logic       con_out_q, con_out_d;
    logic       con_valid_q, con_valid_d;
    logic       cond_ill_q, cond_ill_d;
    logic       evt_s;
    logic [1:0] eval_s;

    // Rising-edge detect: a con_in held high evaluates only once.
    assign evt_s  = con_in & ~con_in_q;
    assign eval_s = cond_eval(bus_in, cond_code);

    // Next-state and result logic; a new evaluation wins over con_clr.
    always_comb begin
        state_d    = state_q;
        con_out_d  = con_out_q;
        cond_ill_d = cond_ill_q;
        case (state_q)
            ST_IDLE: begin
                if (evt_s) begin
                    state_d    = ST_VALID;
                    con_out_d  = eval_s[0];
                    cond_ill_d = eval_s[1];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VALID: begin
                if (evt_s) begin
                    state_d    = ST_VALID;
                    con_out_d  = eval_s[0];
                    cond_ill_d = eval_s[1];
                end else if (con_clr) begin
                    state_d    = ST_IDLE;
                    con_out_d  = 1'b0;
                    cond_ill_d = 1'b0;
                end else begin
                    state_d = ST_VALID;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                con_out_d  = 1'b0;
                cond_ill_d = 1'b0;
            end
        endcase
        con_valid_d = (state_d == ST_VALID);
    end

    // State, edge-detect and output registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            con_in_q    <= 1'b0;
            con_out_q   <= 1'b0;
            con_valid_q <= 1'b0;
            cond_ill_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            con_in_q    <= con_in;
            con_out_q   <= con_out_d;
            con_valid_q <= con_valid_d;
            cond_ill_q  <= cond_ill_d;
        end
    end

    assign con_out   = con_out_q;
    assign con_valid = con_valid_q;
    assign cond_ill  = cond_ill_q;

`ifdef CON_STATS_EN
    logic [CNT_W-1:0] eval_cnt_q, eval_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    // Saturating statistics; only the async reset clears them, not con_clr.
    always_comb begin
        eval_cnt_d  = eval_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (evt_s) begin
            if (eval_cnt_q != {CNT_W{1'b1}}) begin
                eval_cnt_d = eval_cnt_q + CNT_W'(1);
            end else begin
                eval_cnt_d = eval_cnt_q;
            end
            if (eval_s[0] && (taken_cnt_q != {CNT_W{1'b1}})) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end else begin
                taken_cnt_d = taken_cnt_q;
            end
        end else begin
            eval_cnt_d  = eval_cnt_q;
            taken_cnt_d = taken_cnt_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            eval_cnt_q  <= {CNT_W{1'b0}};
            taken_cnt_q <= {CNT_W{1'b0}};
        end else begin
            eval_cnt_q  <= eval_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign eval_cnt  = eval_cnt_q;
    assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_con_ff_unit.sv
// -----------------------------------------------------------------------------
// tb_con_ff_unit
// Directed self-checking bench for con_ff_unit. A reference model computes the
// expected outputs whenever stimulus is driven and pushes them to a scoreboard
// queue; entries are popped and compared once the DUT has had its clock edge.
// Counter checks are included when CON_STATS_EN is defined (CNT_W = 2).
// -----------------------------------------------------------------------------
module tb_con_ff_unit;

`ifdef CON_STATS_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 16;
`endif
    localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

    logic        clock;
    logic        clear;
    logic [31:0] bus_in;
    logic [3:0]  cond_code;
    logic        con_in;
    logic        con_clr;
    logic        con_out;
    logic        con_valid;
    logic        cond_ill;
`ifdef CON_STATS_EN
    logic [TB_CNT_W-1:0] eval_cnt;
    logic [TB_CNT_W-1:0] taken_cnt;
`endif

    con_ff_unit #(
        .DATA_W(32),
        .CODE_W(4),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .bus_in   (bus_in),
        .cond_code(cond_code),
        .con_in   (con_in),
        .con_clr  (con_clr),
        .con_out  (con_out),
        .con_valid(con_valid),
        .cond_ill (cond_ill)
`ifdef CON_STATS_EN
        ,
        .eval_cnt (eval_cnt),
        .taken_cnt(taken_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic  o;
        logic  v;
        logic  i;
        int    ev;
        int    tk;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic m_out, m_valid, m_ill;
    int   m_ev, m_tk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model_cond(input logic [31:0] bus, input logic [3:0] code,
                                       output logic d, output logic ill);
        int sb_val;
        sb_val = $signed(bus);
        ill = (code > 4'd7);
        d   = 1'b0;
        if (!ill) begin
            case (code)
                4'd0: d = (bus == 32'd0);
                4'd1: d = (bus != 32'd0);
                4'd2: d = (sb_val >= 0);
                4'd3: d = (sb_val < 0);
                4'd4: d = (sb_val > 0);
                4'd5: d = (sb_val <= 0);
                4'd6: d = 1'b1;
                default: d = 1'b0;
            endcase
        end
    endfunction

    task automatic model_evt(input logic [31:0] bus, input logic [3:0] code);
        logic d, ill;
        model_cond(bus, code, d, ill);
        m_out   = d;
        m_ill   = ill;
        m_valid = 1'b1;
        if (m_ev < CNT_MAX) m_ev++;
        if (d && m_tk < CNT_MAX) m_tk++;
    endtask

    task automatic model_reset();
        m_out = 1'b0; m_valid = 1'b0; m_ill = 1'b0; m_ev = 0; m_tk = 0;
    endtask

    task automatic push(input string tag);
        exp_t e;
        e.o = m_out; e.v = m_valid; e.i = m_ill; e.ev = m_ev; e.tk = m_tk; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed 0 expected 1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_out"},   32'(con_out),   32'(e.o));
            chk({e.tag, "_valid"}, 32'(con_valid), 32'(e.v));
            chk({e.tag, "_ill"},   32'(cond_ill),  32'(e.i));
`ifdef CON_STATS_EN
            chk({e.tag, "_evcnt"}, 32'(eval_cnt),  32'(e.ev));
            chk({e.tag, "_tkcnt"}, 32'(taken_cnt), 32'(e.tk));
`endif
        end
    endtask

    // Wait for the active edge and sample just after it.
    task automatic tick_check(input string tag);
        push(tag);
        @(posedge clock);
        #1;
        pop_check();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        clear = 1'b0; con_in = 1'b0; con_clr = 1'b0;
        #1;
        model_reset();
        push(tag);
        pop_check();
        @(negedge clock);
        clear = 1'b1;
    endtask

    // One con_in pulse; afterwards the inputs are scrambled to show they
    // were sampled only on the evaluation edge.
    task automatic eval_step(input string tag, input logic [31:0] bus,
                             input logic [3:0] code, input logic clr);
        @(negedge clock);
        bus_in = bus; cond_code = code; con_in = 1'b1; con_clr = clr;
        model_evt(bus, code);
        tick_check(tag);
        @(negedge clock);
        con_in = 1'b0; con_clr = 1'b0;
        bus_in = ~bus; cond_code = code ^ 4'd1;
        tick_check({tag, "_hold"});
    endtask

    initial begin
        clear = 1'b1; bus_in = 32'd0; cond_code = 4'd0; con_in = 1'b0; con_clr = 1'b0;
        model_reset();
        #2;
        do_reset("reset");

        // 1: zero test
        eval_step("t1_z", 32'd0, 4'd0, 1'b0);
        // 2: sign tests
        eval_step("t2_neg", 32'h8000_0000, 4'd3, 1'b0);
        eval_step("t2_ge0", 32'h8000_0000, 4'd2, 1'b0);
        // 3: greater / less-equal
        eval_step("t3_gt_pos", 32'd5, 4'd4, 1'b0);
        eval_step("t3_gt_zero", 32'd0, 4'd4, 1'b0);
        eval_step("t3_le_zero", 32'd0, 4'd5, 1'b0);
        eval_step("t3_nz", 32'h0000_0100, 4'd1, 1'b0);
        eval_step("t3_never", 32'd0, 4'd7, 1'b0);

        // 4: illegal code, con_in held high for five cycles
        do_reset("t4_reset");
        @(negedge clock);
        bus_in = 32'd0; cond_code = 4'b1001; con_in = 1'b1;
        model_evt(32'd0, 4'b1001);
        tick_check("t4_ill");
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            cond_code = 4'd6;
            tick_check("t4_held");
        end
        @(negedge clock);
        con_in = 1'b0;
        tick_check("t4_release");

        // 5: clear handshake
        eval_step("t5_set", 32'd0, 4'd6, 1'b0);
        @(negedge clock);
        con_clr = 1'b1;
        m_out = 1'b0; m_valid = 1'b0; m_ill = 1'b0;
        tick_check("t5_clr");
        tick_check("t5_clr_idle");
        @(negedge clock);
        con_clr = 1'b0;
        eval_step("t5_set2", 32'hFFFF_FFFF, 4'd3, 1'b0);
        eval_step("t5_clr_evt", 32'd7, 4'd2, 1'b1);

        // 6: saturation, then reset mid-pulse
        do_reset("t6_reset");
        for (int k = 0; k < 5; k++) eval_step("t6_taken", 32'(k), 4'd6, 1'b0);
        @(negedge clock);
        bus_in = 32'd0; cond_code = 4'd0; con_in = 1'b1;
        model_evt(32'd0, 4'd0);
        tick_check("t6_pulse");
        #2;
        clear = 1'b0;
        #1;
        model_reset();
        push("t6_async_clear");
        pop_check();
        // con_in held across reset release counts as a rising edge
        @(negedge clock);
        clear = 1'b1;
        bus_in = 32'd9; cond_code = 4'd1;
        model_evt(32'd9, 4'd1);
        tick_check("t6_release_edge");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
